// File: rtl/carry_save_resolver.sv
// -----------------------------------------------------------------------------
// carry_save_resolver
//
// Purpose:
//   Converts a carry-save operand pair (sum word s, carry word c with c bit i
//   weighing 2^(i+1)) into a plain binary value d_out = s + 2*c. The addition
//   is done serially, one CW-bit chunk per clock, so only a CW-bit adder is
//   built regardless of DW. A result appears NCH = DW/CW edges after the
//   operand pair is accepted.
//
// Parameters:
//   DW        width of each carry-save input word
//   CW        chunk width added per cycle (DW must be a multiple of CW)
//
// Ports:
//   clk       single clock, rising edge active
//   rst_n     asynchronous active-low reset
//   in_valid  operand pair on d_in_c/d_in_s is valid
//   in_ready  block can accept an operand pair this cycle
//   d_in_c    carry word (bit i has weight 2^(i+1))
//   d_in_s    sum word   (bit i has weight 2^i)
//   out_valid d_out holds a resolved result
//   out_ready consumer takes the result this cycle
//   d_out     resolved binary value, DW+2 bits wide
// -----------------------------------------------------------------------------
module carry_save_resolver #(
   parameter int DW = 64,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] d_in_c,
   input  logic [DW-1:0] d_in_s,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW+1:0] d_out
);

   localparam int NCH = DW / CW;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // One chunk of the ripple: a + b + cin, with the carry-out in the MSB.
   function automatic logic [CW:0] chunk_add(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b,
                                             input logic          cin);
      return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
   endfunction

   // The two bits above DW: the carry word's MSB (weight 2^DW once shifted)
   // plus the final ripple carry. The sum never exceeds 2, so 2 bits suffice.
   function automatic logic [1:0] top_add(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   logic [1:0]    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic [DW+1:0] dout_q, dout_d;

   logic [DW-1:0] c_q, s_q;
   logic [DW-1:0] c2_w;
   logic [CW-1:0] s_chunk, c_chunk;
   logic [CW:0]   chunk_sum;
   logic [1:0]    top_sum;
   logic          accept;

   // Handshake: a new pair may enter from IDLE, or from DONE in the same
   // edge that the consumer takes the previous result.
   assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign d_out     = dout_q;

   // Carry word aligned to sum-word weights; its MSB is handled by top_add.
   assign c2_w = {c_q[DW-2:0], 1'b0};

   // Chunk k of both aligned operands.
   always_comb begin
      s_chunk = '0;
      c_chunk = '0;
      for (int i = 0; i < NCH; i++) begin
         if (k_q == KW'(i)) begin
            s_chunk = s_q[i*CW +: CW];
            c_chunk = c2_w[i*CW +: CW];
         end
      end
   end

   assign chunk_sum = chunk_add(s_chunk, c_chunk, carry_q);
   assign top_sum   = top_add(c_q[DW-1], chunk_sum[CW]);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      dout_d  = dout_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_RUN;
               k_d     = '0;
               carry_d = 1'b0;
            end
         end

         ST_RUN: begin
            // Only chunk k is written; chunks not yet reached keep their
            // old contents until the operation completes.
            for (int i = 0; i < NCH; i++) begin
               if (k_q == KW'(i)) begin
                  dout_d[i*CW +: CW] = chunk_sum[CW-1:0];
               end
            end
            carry_d = chunk_sum[CW];
            if (k_q == K_LAST) begin
               dout_d[DW+1:DW] = top_sum;
               state_d         = ST_DONE;
               k_d             = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  // Consume and restart on the same edge.
                  state_d = ST_RUN;
                  k_d     = '0;
                  carry_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            k_d     = '0;
            carry_d = 1'b0;
         end
      endcase
   end

   // Control and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         dout_q  <= dout_d;
      end
   end

   // Operand capture: the source is free to change its inputs after the
   // accepting edge, so both words are held here for the whole operation.
   always_ff @(posedge clk) begin
      if (accept) begin
         c_q <= d_in_c;
         s_q <= d_in_s;
      end
   end

endmodule

// File: tb/tb_carry_save_resolver.sv
module tb_carry_save_resolver;

   localparam int DW = 64;
   localparam int CW = 16;
   localparam int NRAND = 8000;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] d_in_c;
   logic [DW-1:0] d_in_s;
   logic          out_valid;
   logic          out_ready;
   logic [DW+1:0] d_out;

   carry_save_resolver #(.DW(DW), .CW(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .d_in_c   (d_in_c),
      .d_in_s   (d_in_s),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .d_out    (d_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [DW+1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int n_push = 0;
   int n_pop = 0;
   int n_flushed = 0;
   bit rand_done = 0;

   task automatic check1(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %0b expected %0b at %0t", name, got, req, $time);
      end
   endtask

   task automatic check_w(input string name, input logic [DW+1:0] got, input logic [DW+1:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, req, $time);
      end
   endtask

   // Scoreboard monitor: pops one expected value per output handshake and
   // checks that a stalled result stays put.
   task automatic monitor();
      logic [DW+1:0] prev;
      logic [DW+1:0] e;
      bit hold;
      hold = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 0;
            continue;
         end
         if (hold) begin
            check1("hold_valid", out_valid, 1'b1);
            check_w("hold_data", d_out, prev);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dup_result got %h expected none at %0t", d_out, $time);
            end else begin
               e = exp_q.pop_front();
               n_pop++;
               check_w("result", d_out, e);
            end
         end
         hold = out_valid && !out_ready;
         if (hold) begin
            check1("hold_in_ready", in_ready, 1'b0);
            prev = d_out;
         end
      end
   endtask

   // Present a pair until accepted; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [DW-1:0] c, input logic [DW-1:0] s, input logic [DW+1:0] e);
      int n;
      bit acc;
      d_in_c   = c;
      d_in_s   = s;
      in_valid = 1'b1;
      acc = 0;
      n = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            exp_q.push_back(e);
            n_push++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      d_in_c = {$urandom, $urandom};
      d_in_s = {$urandom, $urandom};
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got in_ready=0 expected 1 at %0t", $time);
      end
   endtask

   task automatic check_latency();
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         check1("latency", out_valid, (e == 4));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check1("drain_empty", (exp_q.size() == 0), 1'b1);
   endtask

   initial begin
      logic [DW-1:0] rc, rs;
      logic [DW+1:0] re;
      int n;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d_in_c    = '0;
      d_in_s    = '0;
      fork
         monitor();
      join_none

      // Reset state
      #1;
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check_w("rst_d_out", d_out, '0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check1("post_rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;

      // Simple value, with exact latency
      send(64'h0, 64'h1234, 66'h1234);
      check_latency();
      // All ones on both words
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 66'h2_FFFF_FFFF_FFFF_FFFD);
      check_latency();
      // Full-width carry ripple
      send(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 66'h1_0000_0000_0000_0001);
      check_latency();
      // Carry-word MSB lands above DW
      send(64'h8000_0000_0000_0000, 64'h0, 66'h1_0000_0000_0000_0000);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 66'h1_FFFF_FFFF_FFFF_FFFE);
      // Carry across the first chunk boundary
      send(64'h8000, 64'hFFFF, 66'h1_FFFF);
      drain();

      // Backpressure in DONE
      out_ready = 1'b0;
      send(64'h1111, 64'h2222, 66'h4444);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (5) begin
         check1("bp_out_valid", out_valid, 1'b1);
         check1("bp_in_ready", in_ready, 1'b0);
         check_w("bp_d_out", d_out, 66'h4444);
         @(posedge clk);
         #1;
      end
      // Release with a new pair on the same edge
      out_ready = 1'b1;
      send(64'h0, 64'h7, 66'h7);
      check_latency();
      drain();

      // Reset in the middle of an operation (k==2)
      send(64'h1, 64'h3, 66'h5);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      n_flushed += exp_q.size();
      exp_q.delete();
      #1;
      check1("midrst_out_valid", out_valid, 1'b0);
      check_w("midrst_d_out", d_out, '0);
      check1("midrst_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         check1("postrst_in_ready", in_ready, 1'b1);
         check1("postrst_no_stale", out_valid, 1'b0);
         @(posedge clk);
         #1;
      end
      send(64'h0000_0000_0001_0000, 64'h0000_0000_0000_0005, 66'h2_0005);
      check_latency();
      drain();

      // Random regression with random handshakes
      fork
         begin
            for (int i = 0; i < NRAND; i++) begin
               case ($urandom_range(7))
                  0: rc = '1;
                  1: rc = '0;
                  default: rc = {$urandom, $urandom};
               endcase
               case ($urandom_range(7))
                  0: rs = '1;
                  1: rs = '0;
                  default: rs = {$urandom, $urandom};
               endcase
               re = {2'b00, rs} + {1'b0, rc, 1'b0};
               if ($urandom_range(9) == 0) begin
                  repeat ($urandom_range(1, 3)) begin
                     @(posedge clk);
                     #1;
                  end
               end
               send(rc, rs, re);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(99) < 85);
            end
         end
      join
      out_ready = 1'b1;
      drain();
      check1("no_lost_results", (n_pop == n_push - n_flushed), 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
